// File: rtl/video_pkg.sv
// Shared video-path definitions.
//   tela_t         : screen/phase state codes (value doubles as screen_sel)
//   rgb_t          : packed {R,G,B} pixel, 8 bits per channel
//   *ActiveDefault : default visible area for a 640x480 timing
package video_pkg;

    localparam int unsigned HActiveDefault = 640;
    localparam int unsigned VActiveDefault = 480;

    typedef enum logic [1:0] {
        StTitle = 2'd0,
        StTrans = 2'd1,
        StPlay  = 2'd2,
        StOver  = 2'd3
    } tela_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RgbBlack = '0;

endpackage

// File: rtl/sequenciador_telas_if.sv
// Pixel bus between the raster/renderers and the screen sequencer.
//   h_counter, v_counter : current raster position
//   title_rgb, game_rgb  : candidate pixels from the two renderers
//   R, G, B              : registered pixel going to the DAC
// master: raster + renderer side; slave: the sequencer.
interface sequenciador_telas_if;
    import video_pkg::*;

    logic [9:0] h_counter;
    logic [9:0] v_counter;
    rgb_t       title_rgb;
    rgb_t       game_rgb;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;

    modport master (
        output h_counter, v_counter, title_rgb, game_rgb,
        input  R, G, B
    );

    modport slave (
        input  h_counter, v_counter, title_rgb, game_rgb,
        output R, G, B
    );

endinterface

// File: rtl/frame_divider.sv
// Frame-tick divider: counts tick_i pulses while en_i is high and pulses
// wrap_o (combinationally, same cycle as the tick) when the count is at N-1.
//   clk, reset : clock, synchronous active-high reset
//   en_i       : count enable
//   clr_i      : synchronous clear, overrides counting
//   tick_i     : frame tick
//   wrap_o     : one-cycle pulse on every Nth counted tick
module frame_divider #(
    parameter int unsigned N = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    input  logic tick_i,
    output logic wrap_o
);

    localparam int unsigned W = $clog2(N + 1);
    localparam logic [W-1:0] Last = W'(N - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        wrap_o  = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && tick_i) begin
            if (count_q == Last) begin
                count_d = '0;
                wrap_o  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sequenciador_telas.sv
// Screen sequencer: tracks game phase (title, transition, play, game over),
// generates the sprite animation toggle and selects which renderer reaches
// the DAC through a registered RGB mux.
//   clk, reset   : pixel clock, synchronous active-high reset
//   vid          : pixel bus (raster position, renderer pixels, RGB out)
//   start_btn_i  : asynchronous start button
//   game_over_i  : game-over level, only looked at in play
//   troca_o      : sprite animation frame select
//   game_run_o   : high only in play
//   screen_sel_o : current state code
//   frame_tick_o : one-cycle pulse per frame
module sequenciador_telas
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = HActiveDefault,
    parameter int unsigned V_ACTIVE     = VActiveDefault,
    parameter int unsigned ANIM_FRAMES  = 30,
    parameter int unsigned TRANS_FRAMES = 60,
    parameter int unsigned BLINK_FRAMES = 15,
    parameter int unsigned OVER_FRAMES  = 240
) (
    input  logic                       clk,
    input  logic                       reset,
    sequenciador_telas_if.slave        vid,
    input  logic                       start_btn_i,
    input  logic                       game_over_i,
    output logic                       troca_o,
    output logic                       game_run_o,
    output logic [1:0]                 screen_sel_o,
    output logic                       frame_tick_o
);

    localparam int unsigned PhMax = (TRANS_FRAMES > OVER_FRAMES) ? TRANS_FRAMES : OVER_FRAMES;
    localparam int unsigned PhW   = $clog2(PhMax + 1);
    localparam logic [PhW-1:0] TransLast = PhW'(TRANS_FRAMES - 1);
    localparam logic [PhW-1:0] OverLast  = PhW'(OVER_FRAMES - 1);

    tela_t          state_q, state_d;
    logic [PhW-1:0] phase_q, phase_d;
    logic           cond_q, frame_tick_q;
    logic           sync1_q, sync2_q, start_prev_q;
    logic           troca_q, troca_d;
    logic           blink_on_q, blink_on_d;
    rgb_t           rgb_q, rgb_d;
    logic           cond_raw, start_p, state_chg, anim_wrap, blink_wrap;

    // Edge of the raster condition, so a stalled raster still ticks once.
    assign cond_raw = (vid.h_counter == '0) && (vid.v_counter == 10'(V_ACTIVE));
    assign start_p  = sync2_q & ~start_prev_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (frame_tick_q && (state_q == StTrans || state_q == StOver)) begin
            phase_d = phase_q + 1'b1;
        end
        case (state_q)
            StTitle: if (start_p) state_d = StTrans;
            StTrans: if (frame_tick_q && phase_q == TransLast) state_d = StPlay;
            StPlay:  if (game_over_i) state_d = StOver;
            StOver: begin
                if (start_p) begin
                    state_d = StTrans;
                end else if (frame_tick_q && phase_q == OverLast) begin
                    state_d = StTitle;
                end
            end
            default: state_d = StTitle;
        endcase
        if (state_d != state_q) phase_d = '0;
    end

    assign state_chg = (state_d != state_q);

    frame_divider #(.N(ANIM_FRAMES)) u_anim (
        .clk    (clk),
        .reset  (reset),
        .en_i   (state_q == StTitle || state_q == StPlay),
        .clr_i  (state_chg),
        .tick_i (frame_tick_q),
        .wrap_o (anim_wrap)
    );

    frame_divider #(.N(BLINK_FRAMES)) u_blink (
        .clk    (clk),
        .reset  (reset),
        .en_i   (state_q == StOver),
        .clr_i  (state_chg),
        .tick_i (frame_tick_q),
        .wrap_o (blink_wrap)
    );

    always_comb begin
        troca_d    = troca_q ^ anim_wrap;
        blink_on_d = blink_on_q;
        if (state_d == StOver && state_q != StOver) begin
            blink_on_d = 1'b1;
        end else if (blink_wrap) begin
            blink_on_d = ~blink_on_q;
        end
    end

    // Mux selects on the registered state, so a new screen shows one pixel later.
    always_comb begin
        rgb_d = RgbBlack;
        if (vid.h_counter < 10'(H_ACTIVE) && vid.v_counter < 10'(V_ACTIVE)) begin
            case (state_q)
                StTitle: rgb_d = vid.title_rgb;
                StPlay:  rgb_d = vid.game_rgb;
                StOver:  rgb_d = blink_on_q ? vid.game_rgb : RgbBlack;
                default: rgb_d = RgbBlack;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StTitle;
            phase_q      <= '0;
            cond_q       <= 1'b0;
            frame_tick_q <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            start_prev_q <= 1'b0;
            troca_q      <= 1'b0;
            blink_on_q   <= 1'b0;
            rgb_q        <= RgbBlack;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cond_q       <= cond_raw;
            frame_tick_q <= cond_raw & ~cond_q;
            sync1_q      <= start_btn_i;
            sync2_q      <= sync1_q;
            start_prev_q <= sync2_q;
            troca_q      <= troca_d;
            blink_on_q   <= blink_on_d;
            rgb_q        <= rgb_d;
        end
    end

    assign vid.R        = rgb_q.r;
    assign vid.G        = rgb_q.g;
    assign vid.B        = rgb_q.b;
    assign troca_o      = troca_q;
    assign game_run_o   = (state_q == StPlay);
    assign screen_sel_o = state_q;
    assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_sequenciador_telas.sv
// Bench for sequenciador_telas with default parameters. The raster is
// compressed: a "frame" is one cycle at (0,480) followed by one idle cycle.
module tb_sequenciador_telas;
    import video_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_btn;
    logic       game_over;
    logic       troca;
    logic       game_run;
    logic [1:0] screen_sel;
    logic       frame_tick;

    int checks = 0;
    int failures = 0;
    logic [23:0] exp_q[$];
    logic [23:0] got;
    logic [23:0] want;

    sequenciador_telas_if vif ();

    sequenciador_telas dut (
        .clk          (clk),
        .reset        (reset),
        .vid          (vif),
        .start_btn_i  (start_btn),
        .game_over_i  (game_over),
        .troca_o      (troca),
        .game_run_o   (game_run),
        .screen_sel_o (screen_sel),
        .frame_tick_o (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_pos();
        vif.h_counter = 10'd100;
        vif.v_counter = 10'd100;
    endtask

    task automatic do_frame();
        vif.h_counter = 10'd0;
        vif.v_counter = 10'd480;
        cyc();
        idle_pos();
        cyc();
    endtask

    task automatic do_frames(input int n);
        for (int i = 0; i < n; i++) do_frame();
    endtask

    // Drives one pixel and records the value expected one clock later.
    task automatic drive_px(input logic [9:0] h, input logic [9:0] v, input logic [23:0] t,
                            input logic [23:0] g, input logic [23:0] e);
        vif.h_counter = h;
        vif.v_counter = v;
        vif.title_rgb = t;
        vif.game_rgb  = g;
        exp_q.push_back(e);
        cyc();
        idle_pos();
    endtask

    task automatic test_reset();
        reset = 1'b1; start_btn = 1'b0; game_over = 1'b0;
        idle_pos();
        vif.title_rgb = 24'h123456;
        vif.game_rgb  = 24'hABCDEF;
        cyc(); cyc();
        reset = 1'b0;
        got = {vif.R, vif.G, vif.B};
        checks++;
        if (got !== 24'h0) begin
            failures++; $display("FAIL reset_rgb: rgb=%h expected 000000", got);
        end
        checks++;
        if ({screen_sel, troca, game_run, frame_tick} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: sel=%0d troca=%b run=%b tick=%b expected all 0",
                     screen_sel, troca, game_run, frame_tick);
        end
    endtask

    task automatic test_title_anim();
        logic exp_t;
        for (int k = 1; k <= 65; k++) begin
            do_frame();
            exp_t = ((k / 30) % 2) == 1;
            checks++;
            if (troca !== exp_t) begin
                failures++; $display("FAIL title_troca tick %0d: troca=%b expected %b", k, troca, exp_t);
            end
        end
        checks++;
        if (screen_sel !== 2'd0) begin
            failures++; $display("FAIL title_sel: sel=%0d expected 0", screen_sel);
        end
        drive_px(10'd320, 10'd240, 24'h123456, 24'hABCDEF, 24'h123456);
        got = {vif.R, vif.G, vif.B}; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            failures++; $display("FAIL title_pixel: rgb=%h expected %h", got, want);
        end
    endtask

    // Raster held on the tick position: only one pulse.
    task automatic test_frame_tick_stall();
        vif.h_counter = 10'd0;
        vif.v_counter = 10'd480;
        cyc();
        checks++;
        if (frame_tick !== 1'b1) begin
            failures++; $display("FAIL tick_rise: frame_tick=%b expected 1", frame_tick);
        end
        cyc(); cyc();
        checks++;
        if (frame_tick !== 1'b0) begin
            failures++; $display("FAIL tick_stall: frame_tick=%b expected 0", frame_tick);
        end
        idle_pos();
        cyc();
    endtask

    task automatic test_start_trans();
        start_btn = 1'b1;
        cyc(); cyc();
        checks++;
        if (screen_sel !== 2'd0) begin
            failures++; $display("FAIL start_early: sel=%0d expected 0", screen_sel);
        end
        cyc();
        checks++;
        if (screen_sel !== 2'd1) begin
            failures++; $display("FAIL start_latency: sel=%0d expected 1", screen_sel);
        end
        cyc(); cyc();
        start_btn = 1'b0;
        cyc(); cyc(); cyc();
        checks++;
        if (screen_sel !== 2'd1) begin
            failures++; $display("FAIL start_single: sel=%0d expected 1", screen_sel);
        end
        drive_px(10'd320, 10'd240, 24'h123456, 24'hABCDEF, 24'h000000);
        got = {vif.R, vif.G, vif.B}; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            failures++; $display("FAIL trans_pixel: rgb=%h expected %h", got, want);
        end
        do_frames(59);
        checks++;
        if (screen_sel !== 2'd1) begin
            failures++; $display("FAIL trans_59: sel=%0d expected 1", screen_sel);
        end
        vif.h_counter = 10'd0;
        vif.v_counter = 10'd480;
        cyc();
        checks++;
        if (frame_tick !== 1'b1 || screen_sel !== 2'd1) begin
            failures++;
            $display("FAIL trans_tick60: tick=%b sel=%0d expected tick 1 sel 1", frame_tick, screen_sel);
        end
        idle_pos();
        cyc();
        checks++;
        if (screen_sel !== 2'd2 || game_run !== 1'b1) begin
            failures++; $display("FAIL play_entry: sel=%0d run=%b expected 2 1", screen_sel, game_run);
        end
        drive_px(10'd320, 10'd240, 24'h123456, 24'hABCDEF, 24'hABCDEF);
        got = {vif.R, vif.G, vif.B}; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            failures++; $display("FAIL play_pixel: rgb=%h expected %h", got, want);
        end
    endtask

    task automatic test_over_vs_start();
        logic [23:0] blink_exp [5];
        int          blink_gap [5];
        blink_exp = '{24'hABCDEF, 24'hABCDEF, 24'h000000, 24'h000000, 24'hABCDEF};
        blink_gap = '{0, 14, 1, 14, 1};
        do_frames(35);
        checks++;
        if (troca !== 1'b1) begin
            failures++; $display("FAIL play_troca: troca=%b expected 1", troca);
        end
        start_btn = 1'b1;
        cyc(); cyc();
        game_over = 1'b1;
        cyc();
        start_btn = 1'b0;
        game_over = 1'b0;
        checks++;
        if (screen_sel !== 2'd3 || game_run !== 1'b0) begin
            failures++; $display("FAIL over_wins: sel=%0d run=%b expected 3 0", screen_sel, game_run);
        end
        for (int i = 0; i < 5; i++) begin
            do_frames(blink_gap[i]);
            drive_px(10'd320, 10'd240, 24'h123456, 24'hABCDEF, blink_exp[i]);
            got = {vif.R, vif.G, vif.B}; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("FAIL blink_%0d: rgb=%h expected %h", i, got, want);
            end
        end
        checks++;
        if (troca !== 1'b1) begin
            failures++; $display("FAIL over_troca_frozen: troca=%b expected 1", troca);
        end
    endtask

    task automatic test_over_exits();
        do_frames(209);
        checks++;
        if (screen_sel !== 2'd3) begin
            failures++; $display("FAIL over_239: sel=%0d expected 3", screen_sel);
        end
        do_frame();
        checks++;
        if (screen_sel !== 2'd0) begin
            failures++; $display("FAIL over_timeout: sel=%0d expected 0", screen_sel);
        end
        start_btn = 1'b1;
        cyc(); cyc(); cyc();
        start_btn = 1'b0;
        do_frames(60);
        checks++;
        if (screen_sel !== 2'd2) begin
            failures++; $display("FAIL run2_play: sel=%0d expected 2", screen_sel);
        end
        game_over = 1'b1;
        cyc();
        game_over = 1'b0;
        checks++;
        if (screen_sel !== 2'd3) begin
            failures++; $display("FAIL run2_over: sel=%0d expected 3", screen_sel);
        end
        do_frames(100);
        start_btn = 1'b1;
        cyc(); cyc();
        checks++;
        if (screen_sel !== 2'd3) begin
            failures++; $display("FAIL run2_wait: sel=%0d expected 3", screen_sel);
        end
        cyc();
        start_btn = 1'b0;
        checks++;
        if (screen_sel !== 2'd1) begin
            failures++; $display("FAIL over_restart: sel=%0d expected 1", screen_sel);
        end
    endtask

    task automatic test_blanking();
        logic [9:0]  hs [3];
        logic [9:0]  vs [3];
        logic [23:0] es [3];
        hs = '{10'd640, 10'd10, 10'd639};
        vs = '{10'd10, 10'd480, 10'd479};
        es = '{24'h000000, 24'h000000, 24'hFFFFFF};
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_px(hs[i], vs[i], 24'hFFFFFF, 24'hABCDEF, es[i]);
            got = {vif.R, vif.G, vif.B}; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("FAIL blank_%0d: rgb=%h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_play();
        start_btn = 1'b1;
        cyc(); cyc(); cyc();
        start_btn = 1'b0;
        do_frames(60);
        do_frames(30);
        drive_px(10'd10, 10'd10, 24'h123456, 24'hABCDEF, 24'hABCDEF);
        got = {vif.R, vif.G, vif.B}; want = exp_q.pop_front(); checks++;
        if (got !== want || troca !== 1'b1 || screen_sel !== 2'd2) begin
            failures++;
            $display("FAIL pre_reset: rgb=%h troca=%b sel=%0d expected %h 1 2", got, troca, screen_sel, want);
        end
        vif.h_counter = 10'd0;
        vif.v_counter = 10'd480;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        idle_pos();
        got = {vif.R, vif.G, vif.B};
        checks++;
        if (got !== 24'h0 || {screen_sel, troca, game_run, frame_tick} !== 5'b0) begin
            failures++;
            $display("FAIL mid_reset: rgb=%h sel=%0d troca=%b run=%b tick=%b expected all 0",
                     got, screen_sel, troca, game_run, frame_tick);
        end
    endtask

    initial begin
        test_reset();
        test_title_anim();
        test_frame_tick_stall();
        test_start_trans();
        test_over_vs_start();
        test_over_exits();
        test_blanking();
        test_reset_mid_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
